cb_rr_param: RTL and testbench
==============================

// Module: cb_rr_param
// PURPOSE
//  Parametrised NPORT x NPORT router crossbar with integrated per-output arbitration.
//  Each output runs a registered round-robin arbiter that locks to one input for a whole packet (head to tail flit).
//  The selected input's data, valid and VC are steered to the output.
//  Sits between the input-VC buffers / route compute and the output links.
// PARAMETERS
//  NPORT   5   number of input ports and of output ports (2..16)
//  DATA_W  64  flit data width
//  VCH_W   2   virtual-channel id width
//  PORT_W  3   destination port field width; must be >= clog2(NPORT)
// PORTS
//  clk     in   1              clock, rising edge
//  rst_    in   1              asynchronous reset, active-low
//  idata   in   NPORT*DATA_W   input flit data; input i occupies [i*DATA_W +: DATA_W]
//  ivalid  in   NPORT          flit valid, one bit per input
//  itail   in   NPORT          tail-flit marker; meaningful only while ivalid[i]=1
//  ivch    in   NPORT*VCH_W    input VC id, one field per input
//  port    in   NPORT*PORT_W   requested output port, one field per input
//  req     in   NPORT          input i requests output port[i]; held high for the whole packet
//  grt     out  NPORT*NPORT    grant; bit [i*NPORT+o] = input i owns output o
//  odata   out  NPORT*DATA_W   output flit data, one slice per output
//  ovalid  out  NPORT          output flit valid
//  ovch    out  NPORT*VCH_W    output VC id, one field per output
// BEHAVIOUR
//  - Reset: all grt, ovalid, odata, ovch = 0; every arbiter goes to IDLE; every RR pointer = 0.
//    Reset is asynchronous and takes effect mid-packet; no flit is completed.
//  - Request to output o from input i: req[i] && port[i]==o. If port[i] >= NPORT, the request is ignored and never granted.
//  - One FSM per output: IDLE, BUSY. State, owner index and RR pointer ptr are registered.
//  - IDLE: if any request is present, the winner is the first requester searching from ptr upward, with wrap.
//    On the next edge: owner <= winner; ptr <= winner+1, wrapping NPORT-1 -> 0; state -> BUSY.
//    The grt bit rises on that same edge (1-cycle grant latency).
//  - BUSY, owner releases: if ivalid[owner] && itail[owner], the state returns to IDLE on the next edge and the grt bit clears.
//    The tail flit itself is forwarded.
//  - BUSY, abort: if req[owner]==0 without a tail flit, the state also returns to IDLE on the next edge.
//  - There is no re-arbitration on the release edge. One IDLE cycle (bubble) always follows a release.
//  - While BUSY, other requesters wait; grt stays 0 for them.
//  - grt is one-hot per output and at most one-hot per input (an input's port field selects one output).
//  - Datapath: ovalid[o] = BUSY && ivalid[owner]; odata/ovch = the owner's slices when BUSY, else 0.
//  - Simultaneous events:
//    - several inputs target one output in the same cycle: RR order decides;
//    - independent outputs arbitrate in parallel with no interaction;
//    - an input may hold a grant on output o while a different input is granted output p in the same cycle.
// CONFIGURATION
//  OUTPUT_REG_EN defined:
//    odata/ovalid/ovch are registered after the mux.
//    Flit latency is owner input -> output + 1 cycle. Registers reset to 0.
//    Grant timing is unchanged.
//  OUTPUT_REG_EN undefined:
//    The output mux is combinational from the registered owner/state.
//    Outputs follow the input in the same cycle while BUSY.
// TESTING (NPORT=5, without OUTPUT_REG_EN unless stated)
//  1. Input 2 requests port 4 at cycle 0 and sends a 3-flit packet (tail on the 3rd flit).
//     -> grt[2*5+4]=1 from cycle 1; ovalid[4] mirrors ivalid[2];
//     -> grt clears on the edge after the tail; ovalid[4]=0 in the following idle cycle.
//  2. Inputs 0, 1 and 3 all request port 0 with 1-flit packets, repeated.
//     -> grant order 0, 1, 3, 0, ...;
//     -> exactly one idle bubble between packets; ptr wraps 4 -> 0 correctly.
//  3. Inputs 0..4 request ports 1, 2, 3, 4, 0 simultaneously.
//     -> all five grants assert in cycle 1; odata[o] = idata of the matching input; no cross-talk.
//  4. Input 1 granted port 3, then drops req mid-packet with no tail.
//     -> grant clears next edge; waiting input 4 is granted one cycle later.
//  5. port[0]=6 with req[0]=1 -> no grt bit ever set for input 0; all outputs stay idle.
//  6. rst_ pulled low mid-packet (asynchronous, between edges).
//     -> grt, ovalid, odata, ovch go 0 immediately.
//     -> after release, the first grant goes to the lowest-index requester (ptr=0).
//     Repeat with OUTPUT_REG_EN defined: data arrives 1 cycle later; grants are identical.

Source files
------------

// File: rtl/cb_rr_param_if.sv
// Crossbar port bundle: per-input flit/request signals in, grants and per-output flits out.
// Parameters must match the cb_rr_param instance they connect to.
//   idata/ivalid/itail/ivch : input flits, one slice per input port
//   port/req                : requested output port and request, one per input
//   grt                     : grant matrix, bit [i*NPORT+o] = input i owns output o
//   odata/ovalid/ovch       : output flits, one slice per output port
// master: the side that drives flits and requests. slave: the crossbar.
interface cb_rr_param_if #(
    parameter int unsigned NPORT  = 5,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned VCH_W  = 2,
    parameter int unsigned PORT_W = 3
);
    logic [NPORT*DATA_W-1:0] idata;
    logic [NPORT-1:0]        ivalid;
    logic [NPORT-1:0]        itail;
    logic [NPORT*VCH_W-1:0]  ivch;
    logic [NPORT*PORT_W-1:0] port;
    logic [NPORT-1:0]        req;
    logic [NPORT*NPORT-1:0]  grt;
    logic [NPORT*DATA_W-1:0] odata;
    logic [NPORT-1:0]        ovalid;
    logic [NPORT*VCH_W-1:0]  ovch;

    modport master (
        output idata, ivalid, itail, ivch, port, req,
        input  grt, odata, ovalid, ovch
    );

    modport slave (
        input  idata, ivalid, itail, ivch, port, req,
        output grt, odata, ovalid, ovch
    );
endinterface

// File: rtl/cb_rr_param.sv
// NPORT x NPORT router crossbar with a packet-locking round-robin arbiter per output.
// Each output is an IDLE/BUSY FSM; once an input wins it owns the output until its tail
// flit is seen or it drops req. A release always leaves one IDLE cycle before the next grant.
// Ports:
//   clk   : clock, rising edge
//   rst_  : asynchronous reset, active low
//   bus   : cb_rr_param_if.slave (inputs flits/requests, outputs grants/flits)
// Build option:
//   OUTPUT_REG_EN : when defined, odata/ovalid/ovch are registered after the mux
//                   (one extra cycle of flit latency, grant timing unchanged);
//                   otherwise the output mux is combinational from owner/state.
module cb_rr_param #(
    parameter int unsigned NPORT  = 5,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned VCH_W  = 2,
    parameter int unsigned PORT_W = 3
) (
    input logic          clk,
    input logic          rst_,
    cb_rr_param_if.slave bus
);

    localparam int unsigned IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q [NPORT];
    state_t           state_d [NPORT];
    logic [IDX_W-1:0] owner_q [NPORT];
    logic [IDX_W-1:0] owner_d [NPORT];
    logic [IDX_W-1:0] ptr_q   [NPORT];
    logic [IDX_W-1:0] ptr_d   [NPORT];
    logic [NPORT-1:0] gnt_q   [NPORT];   // per output, one-hot over inputs
    logic [NPORT-1:0] gnt_d   [NPORT];
    logic [NPORT-1:0] req_m_c [NPORT];   // req_m_c[o][i]: input i requests output o

    logic [NPORT*DATA_W-1:0] mux_data_c;
    logic [NPORT-1:0]        mux_valid_c;
    logic [NPORT*VCH_W-1:0]  mux_vch_c;

    // Request decode; an out-of-range port field matches no output.
    always_comb begin
        for (int o = 0; o < int'(NPORT); o++) begin
            req_m_c[o] = '0;
            for (int i = 0; i < int'(NPORT); i++) begin
                req_m_c[o][i] = bus.req[i] && (bus.port[i*PORT_W +: PORT_W] == PORT_W'(o));
            end
        end
    end

    // Per-output arbiter state registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int o = 0; o < int'(NPORT); o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
                gnt_q[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < int'(NPORT); o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
                gnt_q[o]   <= gnt_d[o];
            end
        end
    end

    // Next-state: round-robin search from ptr in IDLE, release on tail or dropped req in BUSY.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] win;
        int unsigned      idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int o = 0; o < int'(NPORT); o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            gnt_d[o]   = gnt_q[o];
            found      = 1'b0;
            win        = '0;
            for (int unsigned k = 0; k < NPORT; k++) begin
                idx = 32'(ptr_q[o]) + k;
                if (idx >= NPORT) begin
                    idx = idx - NPORT;
                end
                if (!found && req_m_c[o][idx]) begin
                    found = 1'b1;
                    win   = IDX_W'(idx);
                end
            end
            case (state_q[o])
                IDLE: begin
                    if (found) begin
                        state_d[o]      = BUSY;
                        owner_d[o]      = win;
                        ptr_d[o]        = (32'(win) == NPORT - 1) ? '0 : win + 1'b1;
                        gnt_d[o]        = '0;
                        gnt_d[o][win]   = 1'b1;
                    end
                end
                BUSY: begin
                    if ((bus.ivalid[owner_q[o]] && bus.itail[owner_q[o]]) || !bus.req[owner_q[o]]) begin
                        state_d[o] = IDLE;
                        gnt_d[o]   = '0;
                    end
                end
                default: begin
                    state_d[o] = IDLE;
                    gnt_d[o]   = '0;
                end
            endcase
        end
    end

    // Grant matrix is a rewiring of the registered per-output one-hot grants.
    always_comb begin
        bus.grt = '0;
        for (int o = 0; o < int'(NPORT); o++) begin
            for (int i = 0; i < int'(NPORT); i++) begin
                bus.grt[i*NPORT + o] = gnt_q[o][i];
            end
        end
    end

    // Output mux: owner's slices while BUSY, zero otherwise.
    always_comb begin
        mux_data_c  = '0;
        mux_valid_c = '0;
        mux_vch_c   = '0;
        for (int o = 0; o < int'(NPORT); o++) begin
            if (state_q[o] == BUSY) begin
                mux_data_c[o*DATA_W +: DATA_W] = bus.idata[32'(owner_q[o])*DATA_W +: DATA_W];
                mux_vch_c[o*VCH_W +: VCH_W]    = bus.ivch[32'(owner_q[o])*VCH_W +: VCH_W];
                mux_valid_c[o]                 = bus.ivalid[owner_q[o]];
            end
        end
    end

`ifdef OUTPUT_REG_EN
    // Registered outputs: one cycle behind the mux.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bus.odata  <= '0;
            bus.ovalid <= '0;
            bus.ovch   <= '0;
        end else begin
            bus.odata  <= mux_data_c;
            bus.ovalid <= mux_valid_c;
            bus.ovch   <= mux_vch_c;
        end
    end
`else
    assign bus.odata  = mux_data_c;
    assign bus.ovalid = mux_valid_c;
    assign bus.ovch   = mux_vch_c;
`endif

endmodule

// File: tb/tb_cb_rr_param.sv
// Directed bench for cb_rr_param (NPORT=5). Inputs change 1 time unit after the rising
// edge; combinational outputs are sampled 3 units after the edge. With OUTPUT_REG_EN the
// datapath expectations of a cycle are compared just after the following edge.
module tb_cb_rr_param;

    localparam int unsigned NPORT  = 5;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned VCH_W  = 2;
    localparam int unsigned PORT_W = 3;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;

    always #5 clk = ~clk;

    cb_rr_param_if #(.NPORT(NPORT), .DATA_W(DATA_W), .VCH_W(VCH_W), .PORT_W(PORT_W)) xb ();

    cb_rr_param #(.NPORT(NPORT), .DATA_W(DATA_W), .VCH_W(VCH_W), .PORT_W(PORT_W)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (xb)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          o;
        logic        v;
        logic [63:0] d;
        logic [1:0]  vc;
    } dp_t;

    dp_t pend[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cmp_dp(input dp_t p);
        chk({p.tag, ".ovalid"}, 64'(xb.ovalid[p.o]), 64'(p.v));
        chk({p.tag, ".odata"}, xb.odata[p.o*DATA_W +: DATA_W], p.d);
        chk({p.tag, ".ovch"}, 64'(xb.ovch[p.o*VCH_W +: VCH_W]), 64'(p.vc));
    endtask

    task automatic chk_dp(input string tag, input int o, input logic v,
                          input logic [63:0] d, input logic [1:0] vc);
        dp_t p;
        p.tag = tag;
        p.o   = o;
        p.v   = v;
        p.d   = d;
        p.vc  = vc;
`ifdef OUTPUT_REG_EN
        pend.push_back(p);
`else
        cmp_dp(p);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        while (pend.size() > 0) cmp_dp(pend.pop_front());
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_in(input int i, input logic rq, input logic [2:0] pt, input logic v,
                          input logic t, input logic [63:0] d, input logic [1:0] vc);
        xb.req[i]                         = rq;
        xb.port[i*PORT_W +: PORT_W]       = pt;
        xb.ivalid[i]                      = v;
        xb.itail[i]                       = t;
        xb.idata[i*DATA_W +: DATA_W]      = d;
        xb.ivch[i*VCH_W +: VCH_W]         = vc;
    endtask

    task automatic clr_all();
        for (int i = 0; i < int'(NPORT); i++) set_in(i, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 2'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".grt"}, 64'(xb.grt), 64'd0);
        chk({tag, ".ovalid"}, 64'(xb.ovalid), 64'd0);
        chk({tag, ".ovch"}, 64'(xb.ovch), 64'd0);
        for (int o = 0; o < int'(NPORT); o++) begin
            chk($sformatf("%s.odata%0d", tag, o), xb.odata[o*DATA_W +: DATA_W], 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit %0d", 200000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] exp_g [8];
        int          own   [8];

        clr_all();
        rst_ = 1'b0;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_ = 1'b1;

        // Test 1: input 2 -> port 4, 3-flit packet with an invalid middle cycle.
        step();
        set_in(2, 1'b1, 3'd4, 1'b1, 1'b0, 64'h1111_0000_0000_0001, 2'd1);
        settle();
        chk("t1.c0.grt", 64'(xb.grt), 64'd0);
        chk_dp("t1.c0", 4, 1'b0, 64'd0, 2'd0);
        step();
        settle();
        chk("t1.c1.grt", 64'(xb.grt), 64'd1 << 14);
        chk_dp("t1.c1", 4, 1'b1, 64'h1111_0000_0000_0001, 2'd1);
        step();
        set_in(2, 1'b1, 3'd4, 1'b0, 1'b0, 64'h1111_0000_0000_0002, 2'd1);
        settle();
        chk("t1.c2.grt", 64'(xb.grt), 64'd1 << 14);
        chk_dp("t1.c2", 4, 1'b0, 64'h1111_0000_0000_0002, 2'd1);
        step();
        set_in(2, 1'b1, 3'd4, 1'b1, 1'b1, 64'h1111_0000_0000_0003, 2'd1);
        settle();
        chk("t1.c3.grt", 64'(xb.grt), 64'd1 << 14);
        chk_dp("t1.c3", 4, 1'b1, 64'h1111_0000_0000_0003, 2'd1);
        step();
        clr_all();
        settle();
        chk("t1.c4.grt", 64'(xb.grt), 64'd0);
        chk_dp("t1.c4", 4, 1'b0, 64'd0, 2'd0);

        // Test 2: inputs 0,1,3 -> port 0, back-to-back 1-flit packets.
        exp_g = '{64'd0, 64'd1, 64'd0, 64'd1 << 5, 64'd0, 64'd1 << 15, 64'd0, 64'd1};
        own   = '{-1, 0, -1, 1, -1, 3, -1, 0};
        step();
        set_in(0, 1'b1, 3'd0, 1'b1, 1'b1, 64'h2222_0000_0000_00A0, 2'd0);
        set_in(1, 1'b1, 3'd0, 1'b1, 1'b1, 64'h2222_0000_0000_00A1, 2'd1);
        set_in(3, 1'b1, 3'd0, 1'b1, 1'b1, 64'h2222_0000_0000_00A3, 2'd3);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            settle();
            chk($sformatf("t2.c%0d.grt", k), 64'(xb.grt), exp_g[k]);
            if (own[k] >= 0)
                chk_dp($sformatf("t2.c%0d", k), 0, 1'b1, 64'h2222_0000_0000_00A0 | 64'(own[k]), 2'(own[k]));
            else
                chk_dp($sformatf("t2.c%0d", k), 0, 1'b0, 64'd0, 2'd0);
        end
        step();
        clr_all();
        step();

        // Test 3: inputs 0..4 -> ports 1,2,3,4,0 in parallel.
        for (int i = 0; i < int'(NPORT); i++)
            set_in(i, 1'b1, 3'((i + 1) % 5), 1'b1, 1'b0, 64'hC0DE_0000_0000_0000 | 64'(i), 2'(i));
        settle();
        chk("t3.c0.grt", 64'(xb.grt), 64'd0);
        step();
        settle();
        chk("t3.c1.grt", 64'(xb.grt), 64'h0000_0000_0018_2082);
        for (int o = 0; o < int'(NPORT); o++)
            chk_dp($sformatf("t3.c1.o%0d", o), o, 1'b1,
                   64'hC0DE_0000_0000_0000 | 64'((o + 4) % 5), 2'((o + 4) % 5));
        step();
        for (int i = 0; i < int'(NPORT); i++) xb.itail[i] = 1'b1;
        settle();
        chk("t3.c2.grt", 64'(xb.grt), 64'h0000_0000_0018_2082);
        step();
        clr_all();
        settle();
        chk("t3.c3.grt", 64'(xb.grt), 64'd0);
        chk_dp("t3.c3", 0, 1'b0, 64'd0, 2'd0);

        // Test 4: input 1 owns port 3 then aborts; waiting input 4 follows after a bubble.
        step();
        set_in(1, 1'b1, 3'd3, 1'b1, 1'b0, 64'h4444_0000_0000_0001, 2'd1);
        settle();
        chk("t4.c0.grt", 64'(xb.grt), 64'd0);
        step();
        set_in(4, 1'b1, 3'd3, 1'b1, 1'b0, 64'h4444_0000_0000_0004, 2'd2);
        settle();
        chk("t4.c1.grt", 64'(xb.grt), 64'd1 << 8);
        chk_dp("t4.c1", 3, 1'b1, 64'h4444_0000_0000_0001, 2'd1);
        step();
        set_in(1, 1'b0, 3'd3, 1'b0, 1'b0, 64'd0, 2'd0);
        settle();
        chk("t4.c2.grt", 64'(xb.grt), 64'd1 << 8);
        chk_dp("t4.c2", 3, 1'b0, 64'd0, 2'd0);
        step();
        settle();
        chk("t4.c3.grt", 64'(xb.grt), 64'd0);
        chk_dp("t4.c3", 3, 1'b0, 64'd0, 2'd0);
        step();
        settle();
        chk("t4.c4.grt", 64'(xb.grt), 64'd1 << 23);
        chk_dp("t4.c4", 3, 1'b1, 64'h4444_0000_0000_0004, 2'd2);
        step();
        clr_all();
        step();

        // Test 5: out-of-range port field is never granted.
        set_in(0, 1'b1, 3'd6, 1'b1, 1'b1, 64'h5555_0000_0000_0000, 2'd0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("t5.c%0d.grt", k), 64'(xb.grt), 64'd0);
            chk($sformatf("t5.c%0d.ovalid", k), 64'(xb.ovalid), 64'd0);
            step();
        end
        clr_all();
        step();

        // Test 6: asynchronous reset mid-packet, then arbitration restarts from ptr 0.
        set_in(3, 1'b1, 3'd2, 1'b1, 1'b0, 64'h6666_0000_0000_0003, 2'd3);
        settle();
        chk("t6.c0.grt", 64'(xb.grt), 64'd0);
        step();
        settle();
        chk("t6.c1.grt", 64'(xb.grt), 64'd1 << 17);
        chk_dp("t6.c1", 2, 1'b1, 64'h6666_0000_0000_0003, 2'd3);
        step();
        settle();
        rst_ = 1'b0;
        #1;
        chk_all_zero("t6.rst");
        #2;
        rst_ = 1'b1;
        clr_all();
        set_in(2, 1'b1, 3'd2, 1'b1, 1'b1, 64'h6666_0000_0000_0002, 2'd2);
        set_in(4, 1'b1, 3'd2, 1'b1, 1'b1, 64'h6666_0000_0000_0004, 2'd0);
        step();
        settle();
        chk("t6.c3.grt", 64'(xb.grt), 64'd1 << 12);
        chk_dp("t6.c3", 2, 1'b1, 64'h6666_0000_0000_0002, 2'd2);
        step();
        clr_all();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
